// File: rtl/i2c_master_pkg.sv
// Shared PHY command codes and FSM state encoding for the I2C byte controller.
package i2c_master_pkg;

  localparam logic [2:0] PHY_NOP   = 3'd0;
  localparam logic [2:0] PHY_START = 3'd1;
  localparam logic [2:0] PHY_STOP  = 3'd2;
  localparam logic [2:0] PHY_READ  = 3'd3;
  localparam logic [2:0] PHY_WRITE = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WR_BIT,
    ST_RD_ACK,
    ST_RD_BIT,
    ST_WR_ACK,
    ST_STOP
  } state_t;

  function automatic logic [2:0] phy_cmd_of(state_t s);
    logic [2:0] c;
    c = PHY_NOP;
    unique case (s)
      ST_START:  c = PHY_START;
      ST_WR_BIT: c = PHY_WRITE;
      ST_RD_ACK: c = PHY_READ;
      ST_RD_BIT: c = PHY_READ;
      ST_WR_ACK: c = PHY_WRITE;
      ST_STOP:   c = PHY_STOP;
      default:   c = PHY_NOP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/i2c_master_byte_ctrl.sv
// I2C master byte controller: sequences START/8 bits/ACK/STOP on a bit PHY.
// Option I2C_BYTE_CTRL_STOP_ON_NACK_EN: a slave NACK after a write forces STOP.
module i2c_master_byte_ctrl
  import i2c_master_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic       cmd_start_i,
  input  logic       cmd_stop_i,
  input  logic       cmd_write_i,
  input  logic       cmd_read_i,
  input  logic [7:0] tx_byte_i,
  input  logic       ack_i,
  output logic [7:0] rx_byte_o,
  output logic       rx_ack_o,
  output logic       done_o,
  output logic       arb_lost_o,
  output logic       bus_err_o,
  output logic [2:0] phy_cmd_o,
  output logic       phy_data_o,
  input  logic       phy_data_i,
  input  logic       phy_cmd_done_i,
  input  logic       phy_arb_lost_i,
  input  logic       phy_sda_err_i,
  input  logic       phy_scl_err_i
);

  state_t     state_q, state_d;
  logic [2:0] phy_cmd_q, phy_cmd_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       phy_data_q, phy_data_d;
  logic       wr_q, wr_d, rd_q, rd_d;
  logic       stop_q, stop_d, ack_q, ack_d;
  logic       rx_ack_q, rx_ack_d, done_q, done_d;
  logic       arb_q, arb_d, err_q, err_d;
  logic       phy_err, nack_stop, go_stop;

  assign phy_err = phy_arb_lost_i | phy_sda_err_i | phy_scl_err_i;

`ifdef I2C_BYTE_CTRL_STOP_ON_NACK_EN
  assign nack_stop = phy_data_i;
`else
  assign nack_stop = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      phy_cmd_q  <= PHY_NOP;
      phy_data_q <= 1'b1;
      cnt_q      <= 3'd0;
      shift_q    <= 8'h00;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      stop_q     <= 1'b0;
      ack_q      <= 1'b1;
      rx_ack_q   <= 1'b1;
      done_q     <= 1'b0;
      arb_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      phy_cmd_q  <= phy_cmd_d;
      phy_data_q <= phy_data_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      stop_q     <= stop_d;
      ack_q      <= ack_d;
      rx_ack_q   <= rx_ack_d;
      done_q     <= done_d;
      arb_q      <= arb_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    stop_d   = stop_q;
    ack_d    = ack_q;
    rx_ack_d = rx_ack_q;
    arb_d    = arb_q;
    err_d    = err_q;
    done_d   = 1'b0;
    go_stop  = 1'b0;
    if (state_q != ST_IDLE && phy_err) begin
      state_d = ST_IDLE;
      arb_d   = arb_q | phy_arb_lost_i;
      err_d   = err_q | phy_sda_err_i | phy_scl_err_i;
      done_d  = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: if (cmd_valid_i) begin
          shift_d = tx_byte_i;
          cnt_d   = 3'd7;
          wr_d    = cmd_write_i;
          rd_d    = cmd_read_i & ~cmd_write_i;
          stop_d  = cmd_stop_i;
          ack_d   = ack_i;
          arb_d   = 1'b0;
          err_d   = 1'b0;
          if (cmd_start_i)      state_d = ST_START;
          else if (cmd_write_i) state_d = ST_WR_BIT;
          else if (cmd_read_i)  state_d = ST_RD_BIT;
          else if (cmd_stop_i)  state_d = ST_STOP;
          else                  done_d  = 1'b1;
        end
        ST_START: if (phy_cmd_done_i) begin
          state_d = wr_q   ? ST_WR_BIT :
                    rd_q   ? ST_RD_BIT :
                    stop_q ? ST_STOP   : ST_IDLE;
          done_d  = ~(wr_q | rd_q | stop_q);
        end
        ST_WR_BIT: if (phy_cmd_done_i) begin
          shift_d = {shift_q[6:0], 1'b0};
          cnt_d   = (cnt_q == 3'd0) ? 3'd0 : cnt_q - 3'd1;
          if (cnt_q == 3'd0) state_d = ST_RD_ACK;
        end
        ST_RD_ACK: if (phy_cmd_done_i) begin
          rx_ack_d = phy_data_i;
          go_stop  = stop_q | nack_stop;
          state_d  = go_stop ? ST_STOP : ST_IDLE;
          done_d   = ~go_stop;
        end
        ST_RD_BIT: if (phy_cmd_done_i) begin
          shift_d = {shift_q[6:0], phy_data_i};
          cnt_d   = (cnt_q == 3'd0) ? 3'd0 : cnt_q - 3'd1;
          if (cnt_q == 3'd0) state_d = ST_WR_ACK;
        end
        ST_WR_ACK: if (phy_cmd_done_i) begin
          state_d = stop_q ? ST_STOP : ST_IDLE;
          done_d  = ~stop_q;
        end
        ST_STOP: if (phy_cmd_done_i) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    // PHY command follows the next state, so it only moves on done/accept/abort
    phy_cmd_d  = phy_cmd_of(state_d);
    phy_data_d = (state_d == ST_WR_BIT) ? shift_d[7] :
                 (state_d == ST_WR_ACK) ? ack_d : 1'b1;
  end

  assign cmd_ready_o = (state_q == ST_IDLE);
  assign rx_byte_o   = shift_q;
  assign rx_ack_o    = rx_ack_q;
  assign done_o      = done_q;
  assign arb_lost_o  = arb_q;
  assign bus_err_o   = err_q;
  assign phy_cmd_o   = phy_cmd_q;
  assign phy_data_o  = phy_data_q;

endmodule
